endstop_monitor: RTL
====================

Name: endstop_monitor

Overview:
- Per-axis limit-switch and position monitor, downstream of an acc_profile_gen (consumes its step/dir strobes) and upstream of the motion pipeline's abort input.
- Synchronises and debounces min/max endstop pins and tracks absolute step position.
- When armed, a debounced endstop hit latches the position, emits a one-cycle abort strobe and raises a one-cycle interrupt pulse for the s3g executor.

Parameters:
POS_W, 32, width of position and trigger-position registers
DB_W, 16, width of debounce threshold and counters
MIN_ACTIVE_LOW, 0, 1 = min pin asserted when low
MAX_ACTIVE_LOW, 0, 1 = max pin asserted when low

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
step_stb  in  1  one-cycle step strobe from profile generator
step_dir  in  1  direction qualifying step_stb; 1 = +1, 0 = -1
endstop_min_in  in  1  raw asynchronous min-limit pin
endstop_max_in  in  1  raw asynchronous max-limit pin
debounce_n  in  DB_W  debounce threshold in cycles
arm  in  1  strobe: IDLE -> ARMED
disarm  in  1  strobe: ARMED -> IDLE
clear  in  1  strobe: TRIGGERED -> IDLE
set_pos  in  1  strobe: load pos_val into position
pos_val  in  POS_W  value loaded by set_pos
position  out  POS_W  current step position
trig_pos  out  POS_W  position latched at trigger
trig_src  out  2  bit0 = min caused trigger, bit1 = max caused trigger
endstops  out  2  debounced states {max, min}, 1 = asserted
armed  out  1  high in ARMED
abort  out  1  one-cycle abort strobe
hit  out  1  one-cycle interrupt pulse, same cycle as abort

Behaviour:
- Reset (clk edge with rst = 1) clears everything to 0: position, trig_pos, trig_src, endstops, armed, abort, hit, debounce counters, synchronisers. State goes to IDLE. rst overrides all strobes.
- Input path: 2-FF synchroniser per pin, then polarity inversion per the *_ACTIVE_LOW parameter, giving s (1 = asserted).
- Debounce, per pin, with debounced value d and counter c:
  - s == d: c <= 0.
  - s != d and c == debounce_n: d <= s, c <= 0.
  - otherwise c <= c + 1.
  - debounce_n = 0: d follows s one cycle after they differ.
  - A glitch shorter than debounce_n + 1 cycles never changes d.
- Position update:
  - set_pos: position <= pos_val; takes priority over a same-cycle step_stb.
  - otherwise on step_stb: position +/- 1 per step_dir, wrapping modulo 2^POS_W.
  - step_dir is ignored without step_stb.
- States: IDLE, ARMED, TRIGGERED. Transitions are evaluated on the registered debounced values at cycle t.
  - IDLE: arm -> ARMED; disarm and clear are ignored.
  - ARMED, either d asserted:
    - at t+1: state TRIGGERED, abort = 1, hit = 1.
    - trig_pos <= the position value registered at t+1 (includes any step or set_pos at t).
    - trig_src <= {d_max, d_min} sampled at t.
    - Both asserted together gives trig_src = 2'b11.
    - Trigger takes priority over a same-cycle disarm.
  - ARMED, disarm with no trigger: -> IDLE.
  - TRIGGERED: holds trig_pos and trig_src; arm is ignored. clear -> IDLE (clear beats arm in the same cycle). trig_pos and trig_src are retained until the next trigger.
  - arm while an endstop is already debounced-asserted: ARMED at t+1, trigger at t+2 (abort/hit high for exactly one cycle).
- abort and hit are registered one-cycle pulses; they never repeat while in TRIGGERED.
- Position keeps counting in every state; steps issued after abort are still counted.
- Changing debounce_n mid-count takes effect immediately; the counter is compared against the new value.

Optional Feature:
- Macro: ENDSTOP_GLITCH_COUNT_EN.
- Defined:
  - Adds output glitch_cnt, 16 bits.
  - Increments (saturating at 0xFFFF) whenever s returns to d with c != 0, i.e. a rejected bounce on either pin.
  - Cleared by rst and by clear.
- Undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Package endstop_pkg:
  - state encoding constants ST_IDLE = 0, ST_ARMED = 1, ST_TRIGGERED = 2.
  - trig_src bit indices SRC_MIN = 0, SRC_MAX = 1.
- Sub-module endstop_debounce (sync + polarity + debounce, parameters DB_W and ACTIVE_LOW), instantiated twice.
- The top of the block holds the position counter, state machine and latches.

Test Plan:
- Debounce: debounce_n = 3; min pin high for 3 cycles then low -> endstops stays 0. Held high -> endstops[0] = 1 exactly 2 + 4 cycles after the pin edge.
- Position: set_pos with pos_val = 0xFFFFFFFE, then 3 steps with dir = 1 -> position = 1. Then set_pos = 10 in the same cycle as a step -> position = 10.
- Trigger: arm, 100 steps with dir = 0 from 0, max pin asserted at step 50 with debounce_n = 0 -> single abort/hit pulse, trig_src = 2'b10, trig_pos = position at that cycle (negative value, e.g. 0xFFFFFFCE ± in-flight steps), armed = 0.
- Simultaneous: both pins rise in the same cycle while ARMED -> trig_src = 2'b11, one abort pulse. clear + arm in the same cycle -> IDLE.
- Pre-asserted: min debounced high, pulse arm -> abort exactly 2 cycles after the arm strobe. Further arm strobes in TRIGGERED -> no pulse.
- Reset mid-operation: rst asserted in TRIGGERED with position = 500 -> next cycle all outputs 0 and state IDLE. ENDSTOP_GLITCH_COUNT_EN build: 5 one-cycle bounces with debounce_n = 4 -> glitch_cnt = 5.

Source files
------------

// File: rtl/endstop_pkg.sv
// endstop_pkg: shared types and constants for the endstop monitor.
//   state_t       - monitor state encoding (IDLE / ARMED / TRIGGERED)
//   SRC_MIN/MAX   - bit positions inside trig_src and endstops
//   sat_add       - saturating add used by the optional glitch counter
//                   (ENDSTOP_GLITCH_COUNT_EN builds only)
package endstop_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ARMED     = 2'd1,
      ST_TRIGGERED = 2'd2
   } state_t;

   localparam int SRC_MIN  = 0;
   localparam int SRC_MAX  = 1;
   localparam int GLITCH_W = 16;

   function automatic logic [GLITCH_W-1:0] sat_add(input logic [GLITCH_W-1:0] a,
                                                   input logic [1:0]          b);
      logic [GLITCH_W:0] sum;
      sum = {1'b0, a} + (GLITCH_W+1)'(b);
      return sum[GLITCH_W] ? '1 : sum[GLITCH_W-1:0];
   endfunction

endpackage

// File: rtl/endstop_debounce.sv
// endstop_debounce: one endstop pin -> 2-FF synchroniser -> polarity fix ->
// debounce counter.
//   clk, rst     - clock, synchronous active-high reset
//   pin          - raw asynchronous pin
//   debounce_n   - threshold: level follows s after debounce_n+1 differing cycles
//   level        - debounced value, 1 = asserted
//   bounce       - (ENDSTOP_GLITCH_COUNT_EN only) s returned to level mid-count
module endstop_debounce
   import endstop_pkg::*;
#(
   parameter int DB_W       = 16,
   parameter int ACTIVE_LOW = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pin,
   input  logic [DB_W-1:0] debounce_n,
   output logic            level
`ifdef ENDSTOP_GLITCH_COUNT_EN
   ,
   output logic            bounce
`endif
);

   localparam logic POL = (ACTIVE_LOW != 0);

   logic [1:0]      sync;
   logic            s;
   logic [DB_W-1:0] cnt;

   assign s = sync[1] ^ POL;

`ifdef ENDSTOP_GLITCH_COUNT_EN
   // A nonzero count means s differed from level last cycle without winning.
   assign bounce = (s == level) && (cnt != '0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sync  <= '0;
         level <= 1'b0;
         cnt   <= '0;
      end else begin
         sync <= {sync[0], pin};
         if (s == level) begin
            cnt <= '0;
         end else if (cnt == debounce_n) begin
            // threshold read live, so a new debounce_n applies to a run in flight
            level <= s;
            cnt   <= '0;
         end else begin
            cnt <= cnt + DB_W'(1);
         end
      end
   end

endmodule

// File: rtl/endstop_monitor.sv
// endstop_monitor: per-axis limit-switch and step-position monitor.
//   clk, rst            - clock, synchronous active-high reset
//   step_stb, step_dir  - step strobe and direction (1 = +1) from profile gen
//   endstop_min_in/max  - raw endstop pins
//   debounce_n          - debounce threshold in cycles
//   arm/disarm/clear    - control strobes for the IDLE/ARMED/TRIGGERED machine
//   set_pos, pos_val    - load position (wins over a same-cycle step)
//   position            - current step position (wraps mod 2^POS_W)
//   trig_pos, trig_src  - position and {max,min} cause latched at trigger
//   endstops            - debounced {max, min}
//   armed               - state is ARMED
//   abort, hit          - one-cycle pulses on trigger
//   glitch_cnt          - rejected-bounce counter, present only when
//                         ENDSTOP_GLITCH_COUNT_EN is defined
module endstop_monitor
   import endstop_pkg::*;
#(
   parameter int POS_W          = 32,
   parameter int DB_W           = 16,
   parameter int MIN_ACTIVE_LOW = 0,
   parameter int MAX_ACTIVE_LOW = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step_stb,
   input  logic             step_dir,
   input  logic             endstop_min_in,
   input  logic             endstop_max_in,
   input  logic [DB_W-1:0]  debounce_n,
   input  logic             arm,
   input  logic             disarm,
   input  logic             clear,
   input  logic             set_pos,
   input  logic [POS_W-1:0] pos_val,
   output logic [POS_W-1:0] position,
   output logic [POS_W-1:0] trig_pos,
   output logic [1:0]       trig_src,
   output logic [1:0]       endstops,
   output logic             armed,
   output logic             abort,
   output logic             hit
`ifdef ENDSTOP_GLITCH_COUNT_EN
   ,
   output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

   logic [1:0]       pins;
   logic [1:0]       d;
   logic [POS_W-1:0] pos_nxt;
   state_t           state;
`ifdef ENDSTOP_GLITCH_COUNT_EN
   logic [1:0]       bounce;
`endif

   assign pins = {endstop_max_in, endstop_min_in};

   for (genvar g = 0; g < 2; g++) begin : g_pin
      endstop_debounce #(
         .DB_W       (DB_W),
         .ACTIVE_LOW ((g == SRC_MIN) ? MIN_ACTIVE_LOW : MAX_ACTIVE_LOW)
      ) u_db (
         .clk        (clk),
         .rst        (rst),
         .pin        (pins[g]),
         .debounce_n (debounce_n),
         .level      (d[g])
`ifdef ENDSTOP_GLITCH_COUNT_EN
         ,
         .bounce     (bounce[g])
`endif
      );
   end

   assign endstops = d;
   assign armed    = (state == ST_ARMED);

   // Next position; trig_pos samples this so a step in the trigger cycle counts.
   always_comb begin
      pos_nxt = position;
      if (set_pos)
         pos_nxt = pos_val;
      else if (step_stb)
         pos_nxt = step_dir ? position + POS_W'(1) : position - POS_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         position <= '0;
         trig_pos <= '0;
         trig_src <= '0;
         abort    <= 1'b0;
         hit      <= 1'b0;
      end else begin
         position <= pos_nxt;
         abort    <= 1'b0;
         hit      <= 1'b0;
         case (state)
            ST_IDLE:
               if (arm) state <= ST_ARMED;
            ST_ARMED:
               if (|d) begin
                  // trigger beats a same-cycle disarm
                  state    <= ST_TRIGGERED;
                  abort    <= 1'b1;
                  hit      <= 1'b1;
                  trig_pos <= pos_nxt;
                  trig_src <= d;
               end else if (disarm) begin
                  state <= ST_IDLE;
               end
            ST_TRIGGERED:
               if (clear) state <= ST_IDLE;
            default:
               state <= ST_IDLE;
         endcase
      end
   end

`ifdef ENDSTOP_GLITCH_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst || clear)
         glitch_cnt <= '0;
      else
         glitch_cnt <= sat_add(glitch_cnt, {1'b0, bounce[0]} + {1'b0, bounce[1]});
   end
`endif

endmodule
